// File: rtl/lieat_exu_wbck_pkg.sv
// Shared writeback definitions: datapath widths, source indices and the arbiter pick helper.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif

package lieat_exu_wbck_pkg;

  localparam int XLEN            = `XLEN;
  localparam int REG_AW          = `REG_AW;
  localparam int STARVE_MAX_DFLT = 4;

  // Lower index means higher base priority.
  localparam int WBCK_SRC_LSU = 0;
  localparam int WBCK_SRC_MDV = 1;
  localparam int WBCK_SRC_ALU = 2;
  localparam int WBCK_NSRC    = 3;

  // Keeps only the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [WBCK_NSRC-1:0] pick_first(input logic [WBCK_NSRC-1:0] req);
    return req & (~req + 3'd1);
  endfunction

endpackage

// File: rtl/lieat_exu_wbck_starve_cnt.sv
// Per-source saturating count of consecutive lost arbitrations; flags the source as starved at the limit.
module lieat_wbck_starve_cnt
  import lieat_exu_wbck_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic clk,
  input  logic rstn,
  input  logic valid,
  input  logic ready,
  output logic starved
);

  localparam int             CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = '0;
    if (valid && !ready) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lieat_exu_wbck.sv
// EXU writeback arbiter (LSU > MDV > ALU with starvation preemption) and regfile write register stage.
// Defining LIEAT_WBCK_FWD_EN enables the same-cycle bypass outputs; otherwise fwd_* are tied to 0.
module lieat_exu_wbck
  import lieat_exu_wbck_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_wbck_valid,
  output logic              alu_wbck_ready,
  input  logic [XLEN-1:0]   alu_wbck_data,
  input  logic [REG_AW-1:0] alu_wbck_rd,
  input  logic              lsu_wbck_valid,
  output logic              lsu_wbck_ready,
  input  logic [XLEN-1:0]   lsu_wbck_data,
  input  logic [REG_AW-1:0] lsu_wbck_rd,
  input  logic              mdv_wbck_valid,
  output logic              mdv_wbck_ready,
  input  logic [XLEN-1:0]   mdv_wbck_data,
  input  logic [REG_AW-1:0] mdv_wbck_rd,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  logic [WBCK_NSRC-1:0] vld_s;
  logic [WBCK_NSRC-1:0] starved_s;
  logic [WBCK_NSRC-1:0] gnt_s;
  logic [REG_AW-1:0]    sel_rd_s;
  logic [XLEN-1:0]      sel_data_s;

  logic                 rf_wen_d,   rf_wen_q;
  logic [REG_AW-1:0]    rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0]      rf_wdata_d, rf_wdata_q;

  assign vld_s[WBCK_SRC_LSU] = lsu_wbck_valid;
  assign vld_s[WBCK_SRC_MDV] = mdv_wbck_valid;
  assign vld_s[WBCK_SRC_ALU] = alu_wbck_valid;

  for (genvar i = 0; i < WBCK_NSRC; i++) begin : g_starve
    lieat_wbck_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .valid   (vld_s[i]),
      .ready   (gnt_s[i]),
      .starved (starved_s[i])
    );
  end

  // Starved requesters preempt; base priority resolves ties in both tiers.
  always_comb begin
    gnt_s = '0;
    if (!rstn) begin
      gnt_s = '0;
    end else if (|(starved_s & vld_s)) begin
      gnt_s = pick_first(starved_s & vld_s);
    end else begin
      gnt_s = pick_first(vld_s);
    end
  end

  assign lsu_wbck_ready = gnt_s[WBCK_SRC_LSU];
  assign mdv_wbck_ready = gnt_s[WBCK_SRC_MDV];
  assign alu_wbck_ready = gnt_s[WBCK_SRC_ALU];

  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    if (gnt_s[WBCK_SRC_LSU]) begin
      sel_rd_s   = lsu_wbck_rd;
      sel_data_s = lsu_wbck_data;
    end else if (gnt_s[WBCK_SRC_MDV]) begin
      sel_rd_s   = mdv_wbck_rd;
      sel_data_s = mdv_wbck_data;
    end else if (gnt_s[WBCK_SRC_ALU]) begin
      sel_rd_s   = alu_wbck_rd;
      sel_data_s = alu_wbck_data;
    end else begin
      sel_rd_s   = '0;
      sel_data_s = '0;
    end
  end

  // Writes to x0 are consumed but never reach the regfile; address/data hold otherwise.
  always_comb begin
    rf_wen_d   = (|gnt_s) && (sel_rd_s != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_wen_d) begin
      rf_waddr_d = sel_rd_s;
      rf_wdata_d = sel_data_s;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef LIEAT_WBCK_FWD_EN
  assign fwd_valid = rf_wen_d;
  assign fwd_rd    = sel_rd_s;
  assign fwd_data  = sel_data_s;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_lieat_exu_wbck.sv
// Self-checking bench for lieat_exu_wbck: directed scenarios followed by constrained-random traffic vs a reference model.
module tb_lieat_exu_wbck;
  import lieat_exu_wbck_pkg::*;

  localparam int SM = STARVE_MAX_DFLT;
`ifdef LIEAT_WBCK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [2:0]        vld;
  logic [XLEN-1:0]   dat [3];
  logic [REG_AW-1:0] rdv [3];

  logic              alu_wbck_ready, lsu_wbck_ready, mdv_wbck_ready;
  logic              rf_wen, fwd_valid;
  logic [REG_AW-1:0] rf_waddr, fwd_rd;
  logic [XLEN-1:0]   rf_wdata, fwd_data;

  lieat_exu_wbck dut (
    .clk            (clk),
    .rstn           (rstn),
    .alu_wbck_valid (vld[WBCK_SRC_ALU]),
    .alu_wbck_ready (alu_wbck_ready),
    .alu_wbck_data  (dat[WBCK_SRC_ALU]),
    .alu_wbck_rd    (rdv[WBCK_SRC_ALU]),
    .lsu_wbck_valid (vld[WBCK_SRC_LSU]),
    .lsu_wbck_ready (lsu_wbck_ready),
    .lsu_wbck_data  (dat[WBCK_SRC_LSU]),
    .lsu_wbck_rd    (rdv[WBCK_SRC_LSU]),
    .mdv_wbck_valid (vld[WBCK_SRC_MDV]),
    .mdv_wbck_ready (mdv_wbck_ready),
    .mdv_wbck_data  (dat[WBCK_SRC_MDV]),
    .mdv_wbck_rd    (rdv[WBCK_SRC_MDV]),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: lost-arbitration streak per source and the expected regfile port.
  int                wait_m [3];
  logic              wen_m;
  logic [REG_AW-1:0] waddr_m;
  logic [XLEN-1:0]   wdata_m;
  logic [2:0]        obs_rdy;
  int                winner;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already driven; check readies/bypass mid-cycle and the regfile port after the edge.
  task automatic cycle(input string tag);
    int         w;
    logic [2:0] exp_rdy;
    logic       exp_fv;
    w = -1;
    if (rstn) begin
      for (int p = 0; p < 3; p++)
        if (w < 0 && vld[p] && wait_m[p] >= SM) w = p;
      for (int p = 0; p < 3; p++)
        if (w < 0 && vld[p]) w = p;
    end
    exp_rdy = 3'b000;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_fv = FWD && (w >= 0) && (rdv[w] != '0);
    #3;
    obs_rdy = {alu_wbck_ready, mdv_wbck_ready, lsu_wbck_ready};
    chk({tag, "_rdy"}, 64'(obs_rdy), 64'(exp_rdy));
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(exp_fv));
    chk({tag, "_fwd_rd"}, 64'(fwd_rd), (FWD && w >= 0) ? 64'(rdv[w]) : 64'd0);
    chk({tag, "_fwd_data"}, 64'(fwd_data), (FWD && w >= 0) ? 64'(dat[w]) : 64'd0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      if (!rstn || p == w || !vld[p]) wait_m[p] = 0;
      else if (wait_m[p] < SM) wait_m[p] = wait_m[p] + 1;
    end
    if (!rstn) begin
      wen_m = 1'b0; waddr_m = '0; wdata_m = '0;
    end else if (w >= 0 && rdv[w] != '0) begin
      wen_m = 1'b1; waddr_m = rdv[w]; wdata_m = dat[w];
    end else begin
      wen_m = 1'b0;
    end
    winner = w;
    chk({tag, "_rf_wen"}, 64'(rf_wen), 64'(wen_m));
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(waddr_m));
    chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(wdata_m));
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      wait_m[p] = 0;
      dat[p]    = XLEN'(32'h1000 + p);
      rdv[p]    = REG_AW'(p + 1);
    end
    wen_m = 1'b0; waddr_m = '0; wdata_m = '0; winner = -1;

    // Reset with every source requesting.
    rstn = 1'b0;
    vld  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      cycle("reset");
      chk("reset_no_ready", 64'(obs_rdy), 64'd0);
    end
    chk("reset_wen", 64'(rf_wen), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", 64'(rf_wdata), 64'd0);

    rstn = 1'b1;
    vld  = 3'b000;
    cycle("idle0");

    // Single ALU result.
    vld = 3'b000; vld[WBCK_SRC_ALU] = 1'b1;
    rdv[WBCK_SRC_ALU] = 5'd5; dat[WBCK_SRC_ALU] = 32'hDEADBEEF;
    cycle("single_alu");
    chk("single_alu_ready", 64'(obs_rdy[WBCK_SRC_ALU]), 64'd1);
    chk("single_alu_wen", 64'(rf_wen), 64'd1);
    chk("single_alu_waddr", 64'(rf_waddr), 64'd5);
    chk("single_alu_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    vld = 3'b000;
    cycle("idle1");

    // Base priority with all three valid; each drops valid after its grant.
    vld = 3'b111;
    rdv[WBCK_SRC_LSU] = 5'd1; rdv[WBCK_SRC_MDV] = 5'd2; rdv[WBCK_SRC_ALU] = 5'd3;
    cycle("prio1");
    chk("prio_lsu_first", 64'(obs_rdy), 64'b001);
    chk("prio_lsu_waddr", 64'(rf_waddr), 64'd1);
    vld[WBCK_SRC_LSU] = 1'b0;
    cycle("prio2");
    chk("prio_mdv_second", 64'(obs_rdy), 64'b010);
    chk("prio_mdv_waddr", 64'(rf_waddr), 64'd2);
    vld[WBCK_SRC_MDV] = 1'b0;
    cycle("prio3");
    chk("prio_alu_third", 64'(obs_rdy), 64'b100);
    chk("prio_alu_waddr", 64'(rf_waddr), 64'd3);
    vld = 3'b000;
    cycle("idle2");

    // Starvation: LSU streams continuously while ALU waits.
    vld = 3'b000; vld[WBCK_SRC_LSU] = 1'b1; vld[WBCK_SRC_ALU] = 1'b1;
    rdv[WBCK_SRC_ALU] = 5'd9; dat[WBCK_SRC_ALU] = 32'hA1A1A1A1;
    for (int i = 0; i < 5; i++) begin
      dat[WBCK_SRC_LSU] = 32'h5000 + 32'(i);
      rdv[WBCK_SRC_LSU] = 5'd10;
      cycle("starve");
      if (i < 4) chk("starve_lsu_wins", 64'(obs_rdy), 64'b001);
      else       chk("starve_alu_forced", 64'(obs_rdy), 64'b100);
    end
    chk("starve_alu_wdata", 64'(rf_wdata), 64'hA1A1A1A1);
    vld = 3'b000;
    cycle("idle3");

    // Write to x0 is accepted but suppressed.
    vld[WBCK_SRC_ALU] = 1'b1; rdv[WBCK_SRC_ALU] = 5'd0; dat[WBCK_SRC_ALU] = 32'h1234;
    cycle("x0");
    chk("x0_ready", 64'(obs_rdy[WBCK_SRC_ALU]), 64'd1);
    chk("x0_no_wen", 64'(rf_wen), 64'd0);
    vld = 3'b000;
    cycle("idle4");

    // Bypass from MULDIV.
    vld[WBCK_SRC_MDV] = 1'b1; rdv[WBCK_SRC_MDV] = 5'd7; dat[WBCK_SRC_MDV] = 32'h55;
    cycle("fwd_mdv");
    chk("fwd_mdv_wdata", 64'(rf_wdata), 64'h55);
    vld = 3'b000;
    cycle("idle5");

    // Random traffic; losers hold valid/data until granted, occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      rstn = ($urandom_range(0, 39) != 0);
      for (int p = 0; p < 3; p++) begin
        if (!(vld[p] && winner != p)) begin
          vld[p] = ($urandom_range(0, 99) < 65);
          dat[p] = XLEN'($urandom);
          rdv[p] = REG_AW'($urandom_range(0, 31));
        end
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
